// File: rtl/fft_frame_sequencer_pkg.sv
// Shared types and helpers for the FFT frame sequencer.
package fft_seq_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        WAIT = 2'd1,
        SCAN = 2'd2,
        EMIT = 2'd3
    } seq_state_t;

    localparam int NSAMPLES_DEFAULT = 1024;
    localparam int IDX_W            = $clog2(NSAMPLES_DEFAULT);

    // A bin may win the peak only inside MIN_BIN .. NSamples/2-1 (above that is the mirrored half).
    function automatic logic bin_eligible(input int bin, input int nsamples, input int min_bin);
        return (bin >= min_bin) && (bin <= (nsamples / 2) - 1);
    endfunction

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Stream bundle between the sequencer (master) and its audio source, FFT core, magnitude path and pitch consumer.
interface fft_frame_sequencer_if #(
    parameter int W     = 16,
    parameter int MW    = 33,
    parameter int IDX_W = 10
);
    logic             audio_in_valid;
    logic             audio_in_ready;
    logic [W-1:0]     audio_in_data;
    logic             fft_in_valid;
    logic             fft_in_ready;
    logic [W-1:0]     fft_in_data;
    logic             fft_in_last;
    logic             mag_valid;
    logic             mag_ready;
    logic [MW-1:0]    mag_data;
    logic             mag_last;
    logic             pitch_valid;
    logic             pitch_ready;
    logic [IDX_W-1:0] pitch_data;

    modport master (
        input  audio_in_valid, audio_in_data, fft_in_ready, mag_valid, mag_data, mag_last, pitch_ready,
        output audio_in_ready, fft_in_valid, fft_in_data, fft_in_last, mag_ready, pitch_valid, pitch_data
    );

    modport slave (
        output audio_in_valid, audio_in_data, fft_in_ready, mag_valid, mag_data, mag_last, pitch_ready,
        input  audio_in_ready, fft_in_valid, fft_in_data, fft_in_last, mag_ready, pitch_valid, pitch_data
    );
endinterface

// File: rtl/fft_frame_sequencer_peak_tracker.sv
// Running argmax over magnitude bins; strict compare so ties keep the earliest index.
module peak_tracker #(
    parameter int MW = 33,
    parameter int IW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          en_i,
    input  logic [MW-1:0] mag_i,
    input  logic [IW-1:0] idx_i,
    output logic          take_o,
    output logic [MW-1:0] peak_o,
    output logic [IW-1:0] peak_idx_o
);
    logic [MW-1:0] peak_q, peak_d;
    logic [IW-1:0] idx_q, idx_d;

    // Next peak: clear between frames, otherwise replace only on a strictly larger eligible bin.
    always_comb begin
        take_o = en_i && (mag_i > peak_q);
        peak_d = peak_q;
        idx_d  = idx_q;
        if (clear_i) begin
            peak_d = '0;
            idx_d  = '0;
        end else if (take_o) begin
            peak_d = mag_i;
            idx_d  = idx_i;
        end else begin
            peak_d = peak_q;
            idx_d  = idx_q;
        end
    end

    // Peak registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_q <= '0;
            idx_q  <= '0;
        end else begin
            peak_q <= peak_d;
            idx_q  <= idx_d;
        end
    end

    assign peak_o     = peak_q;
    assign peak_idx_o = idx_q;
endmodule

// File: rtl/fft_frame_sequencer.sv
// Frames audio into NSamples-long FFT blocks, then scans the returned bins and emits the peak bin index.
// Build macro SEQ_THRESH_EN: a frame whose peak is below THRESH re-emits the previous result instead.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int NSamples = 1024,
    parameter int W        = 16,
    parameter int MW       = 33,
    parameter int MIN_BIN  = 2,
    parameter int THRESH   = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    fft_frame_sequencer_if.master bus,
    output logic                  busy,
    output logic                  frame_err
);
    localparam int IW = $clog2(NSamples);
    localparam int CW = IW + 1;

    seq_state_t    state_q;
    logic [IW-1:0] sample_cnt_q;
    logic [CW-1:0] bin_cnt_q;
    logic          mag_ready_q;
    logic          busy_q;
    logic          pitch_valid_q;
    logic [IW-1:0] pitch_data_q;
    logic          frame_err_q;

    logic          in_fill_s;
    logic          audio_xfer_s;
    logic          scanning_s;
    logic          mag_xfer_s;
    logic          pitch_xfer_s;
    logic [CW-1:0] cur_bin_s;
    logic [CW-1:0] bin_inc_s;
    logic          bin_en_s;
    logic          take_s;
    logic [MW-1:0] peak_s;
    logic [IW-1:0] peak_idx_s;
    logic [IW-1:0] final_idx_s;
    logic [IW-1:0] result_s;

    // FILL is a straight pass-through from the audio source to the FFT core; everything else stalls it.
    always_comb begin
        in_fill_s          = (state_q == FILL);
        bus.fft_in_valid   = in_fill_s && bus.audio_in_valid;
        bus.audio_in_ready = in_fill_s && bus.fft_in_ready;
        bus.fft_in_data    = W'(bus.audio_in_data);
        bus.fft_in_last    = in_fill_s && (sample_cnt_q == IW'(NSamples - 1));
    end

    // Handshakes and the index of the bin currently on the bus (WAIT always sees bin 0).
    always_comb begin
        audio_xfer_s = bus.fft_in_valid && bus.audio_in_ready;
        scanning_s   = (state_q == WAIT) || (state_q == SCAN);
        mag_xfer_s   = scanning_s && mag_ready_q && bus.mag_valid;
        pitch_xfer_s = (state_q == EMIT) && pitch_valid_q && bus.pitch_ready;
        cur_bin_s    = (state_q == SCAN) ? bin_cnt_q : CW'(0);
        bin_en_s     = mag_xfer_s && bin_eligible(int'(cur_bin_s), NSamples, MIN_BIN);
        final_idx_s  = take_s ? cur_bin_s[IW-1:0] : peak_idx_s;
        if (cur_bin_s == {CW{1'b1}}) begin
            bin_inc_s = cur_bin_s;
        end else begin
            bin_inc_s = cur_bin_s + CW'(1);
        end
    end

    peak_tracker #(
        .MW (MW),
        .IW (IW)
    ) u_peak (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (pitch_xfer_s),
        .en_i       (bin_en_s),
        .mag_i      (bus.mag_data),
        .idx_i      (cur_bin_s[IW-1:0]),
        .take_o     (take_s),
        .peak_o     (peak_s),
        .peak_idx_o (peak_idx_s)
    );

`ifdef SEQ_THRESH_EN
    logic [IW-1:0] prev_q;
    logic [MW-1:0] final_peak_s;
    logic          weak_s;

    // A weak frame repeats the last accepted result.
    always_comb begin
        final_peak_s = take_s ? bus.mag_data : peak_s;
        weak_s       = (final_peak_s < MW'(THRESH));
        if (weak_s) begin
            result_s = prev_q;
        end else begin
            result_s = final_idx_s;
        end
    end

    // Last accepted result, updated only by frames that clear the threshold.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
        end else if (mag_xfer_s && bus.mag_last && !weak_s) begin
            prev_q <= final_idx_s;
        end else begin
            prev_q <= prev_q;
        end
    end
`else
    localparam int unused_thresh = THRESH;
    logic          unused_peak_s;

    // Plain argmax; the running magnitude is not needed here.
    always_comb begin
        unused_peak_s = ^peak_s;
        result_s      = final_idx_s;
    end
`endif

    // Sequencer FSM with its registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FILL;
            sample_cnt_q  <= '0;
            bin_cnt_q     <= '0;
            mag_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            pitch_valid_q <= 1'b0;
            pitch_data_q  <= '0;
            frame_err_q   <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (audio_xfer_s) begin
                        if (sample_cnt_q == IW'(NSamples - 1)) begin
                            state_q      <= WAIT;
                            sample_cnt_q <= '0;
                            mag_ready_q  <= 1'b1;
                            busy_q       <= 1'b1;
                        end else begin
                            sample_cnt_q <= sample_cnt_q + IW'(1);
                        end
                    end
                end
                WAIT, SCAN: begin
                    if (mag_xfer_s) begin
                        if (bus.mag_last) begin
                            state_q       <= EMIT;
                            bin_cnt_q     <= '0;
                            mag_ready_q   <= 1'b0;
                            pitch_valid_q <= 1'b1;
                            pitch_data_q  <= result_s;
                            if (cur_bin_s != CW'(NSamples - 1)) begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            state_q   <= SCAN;
                            bin_cnt_q <= bin_inc_s;
                        end
                    end
                end
                EMIT: begin
                    if (pitch_xfer_s) begin
                        state_q       <= FILL;
                        pitch_valid_q <= 1'b0;
                        busy_q        <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= FILL;
                    sample_cnt_q  <= '0;
                    bin_cnt_q     <= '0;
                    mag_ready_q   <= 1'b0;
                    busy_q        <= 1'b0;
                    pitch_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mag_ready   = mag_ready_q;
    assign bus.pitch_valid = pitch_valid_q;
    assign bus.pitch_data  = pitch_data_q;
    assign busy            = busy_q;
    assign frame_err       = frame_err_q;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed-plus-random bench for fft_frame_sequencer against an argmax reference model.
module tb_fft_frame_sequencer;
    localparam int NS      = 1024;
    localparam int W       = 16;
    localparam int MW      = 33;
    localparam int IW      = 10;
    localparam int MIN_BIN = 2;
`ifdef SEQ_THRESH_EN
    localparam int THRESH  = 1024;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    logic frame_err;

    int tests = 0;
    int fails = 0;
    logic [MW-1:0] mags [NS];
    int   exp_pitch;
    logic exp_err;
    int   prev_result;

    fft_frame_sequencer_if #(.W(W), .MW(MW), .IDX_W(IW)) bus_if ();

    fft_frame_sequencer #(
        .NSamples (NS),
        .W        (W),
        .MW       (MW),
        .MIN_BIN  (MIN_BIN),
        .THRESH   (1024)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: first strictly-largest magnitude among eligible bins that were delivered.
    task automatic predict(input int last_pos);
        logic [MW-1:0] best;
        int idx;
        best = '0;
        idx  = 0;
        for (int b = MIN_BIN; b <= last_pos && b < NS / 2; b++) begin
            if (mags[b] > best) begin
                best = mags[b];
                idx  = b;
            end
        end
`ifdef SEQ_THRESH_EN
        if (best < MW'(THRESH)) idx = prev_result;
        else prev_result = idx;
`endif
        exp_pitch = idx;
        if (last_pos != NS - 1) exp_err = 1'b1;
    endtask

    task automatic fill_bg(input int mode);
        for (int i = 0; i < NS; i++) begin
            case (mode)
                0:       mags[i] = MW'(10);
                1:       mags[i] = MW'($urandom_range(0, 50));
                default: mags[i] = {1'($urandom), $urandom};
            endcase
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_pitch_valid"}, 64'(bus_if.pitch_valid), 64'(0));
        chk({tag, "_pitch_data"}, 64'(bus_if.pitch_data), 64'(0));
        chk({tag, "_mag_ready"}, 64'(bus_if.mag_ready), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_frame_err"}, 64'(frame_err), 64'(0));
        chk({tag, "_fft_last"}, 64'(bus_if.fft_in_last), 64'(0));
        chk({tag, "_audio_ready"}, 64'(bus_if.audio_in_ready), 64'(bus_if.fft_in_ready));
    endtask

    task automatic send_frame(input int nsamp, input bit full_rate);
        int cnt = 0;
        int guard = 0;
        logic [W-1:0] d;
        while (cnt < nsamp && guard < 20000) begin
            @(posedge clk); #1;
            d = W'($urandom);
            bus_if.audio_in_valid = full_rate ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus_if.fft_in_ready   = full_rate ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus_if.audio_in_data  = d;
            bus_if.mag_valid      = 1'($urandom);
            #1;
            chk("fill_valid", 64'(bus_if.fft_in_valid), 64'(bus_if.audio_in_valid));
            chk("fill_ready", 64'(bus_if.audio_in_ready), 64'(bus_if.fft_in_ready));
            chk("fill_last", 64'(bus_if.fft_in_last), 64'(cnt == NS - 1));
            chk("fill_busy", 64'(busy), 64'(0));
            chk("fill_mag_ready", 64'(bus_if.mag_ready), 64'(0));
            if (bus_if.audio_in_valid && bus_if.audio_in_ready) begin
                chk("fill_data", 64'(bus_if.fft_in_data), 64'(d));
                cnt++;
            end
            guard++;
        end
        chk("fill_count", 64'(cnt), 64'(nsamp));
    endtask

    task automatic send_bins(input int last_pos);
        int b = 0;
        int guard = 0;
        while (b <= last_pos && guard < 20000) begin
            @(posedge clk); #1;
            bus_if.audio_in_valid = 1'b1;
            bus_if.fft_in_ready   = 1'b1;
            bus_if.mag_valid      = ($urandom_range(0, 3) != 0);
            bus_if.mag_data       = mags[b];
            bus_if.mag_last       = (b == last_pos);
            #1;
            chk("scan_busy", 64'(busy), 64'(1));
            chk("scan_audio_stall", 64'(bus_if.audio_in_ready), 64'(0));
            chk("scan_fft_valid", 64'(bus_if.fft_in_valid), 64'(0));
            chk("scan_mag_ready", 64'(bus_if.mag_ready), 64'(1));
            chk("scan_pitch_valid", 64'(bus_if.pitch_valid), 64'(0));
            if (bus_if.mag_valid && bus_if.mag_ready) b++;
            guard++;
        end
        chk("scan_count", 64'(b), 64'(last_pos + 1));
        predict(last_pos);
        @(posedge clk); #1;
        bus_if.mag_valid = 1'b0;
        bus_if.mag_last  = 1'b0;
        #1;
        chk("emit_valid", 64'(bus_if.pitch_valid), 64'(1));
        chk("emit_data", 64'(bus_if.pitch_data), 64'(exp_pitch));
        chk("emit_mag_ready", 64'(bus_if.mag_ready), 64'(0));
        chk("emit_frame_err", 64'(frame_err), 64'(exp_err));
    endtask

    task automatic emit(input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            bus_if.pitch_ready    = 1'b0;
            bus_if.audio_in_valid = 1'b1;
            bus_if.mag_valid      = 1'b1;
            bus_if.mag_data       = {1'($urandom), $urandom};
            #1;
            chk("hold_valid", 64'(bus_if.pitch_valid), 64'(1));
            chk("hold_data", 64'(bus_if.pitch_data), 64'(exp_pitch));
            chk("hold_audio_stall", 64'(bus_if.audio_in_ready), 64'(0));
            chk("hold_mag_ready", 64'(bus_if.mag_ready), 64'(0));
            chk("hold_busy", 64'(busy), 64'(1));
        end
        @(posedge clk); #1;
        bus_if.pitch_ready = 1'b1;
        bus_if.mag_valid   = 1'b0;
        #1;
        chk("hs_valid", 64'(bus_if.pitch_valid), 64'(1));
        chk("hs_data", 64'(bus_if.pitch_data), 64'(exp_pitch));
        @(posedge clk); #1;
        bus_if.pitch_ready    = 1'b0;
        bus_if.audio_in_valid = 1'b0;
        #1;
        chk("post_valid", 64'(bus_if.pitch_valid), 64'(0));
        chk("post_busy", 64'(busy), 64'(0));
        chk("post_audio_ready", 64'(bus_if.audio_in_ready), 64'(bus_if.fft_in_ready));
        chk("post_frame_err", 64'(frame_err), 64'(exp_err));
    endtask

    task automatic run_frame(input int last_pos, input int hold, input bit full_rate);
        send_frame(NS, full_rate);
        send_bins(last_pos);
        emit(hold);
    endtask

    initial begin
        bus_if.audio_in_valid = 1'b0;
        bus_if.audio_in_data  = '0;
        bus_if.fft_in_ready   = 1'b1;
        bus_if.mag_valid      = 1'b0;
        bus_if.mag_data       = '0;
        bus_if.mag_last       = 1'b0;
        bus_if.pitch_ready    = 1'b0;
        exp_err     = 1'b0;
        prev_result = 0;
        exp_pitch   = 0;

        repeat (3) @(posedge clk);
        #2;
        check_reset("rst0");
        reset = 1'b0;

        // Frame A: full-rate fill, single clear peak.
        fill_bg(0);
        mags[100] = MW'(5000);
        run_frame(NS - 1, 0, 1'b1);

        // Frame D: weak peak (below THRESH when that option is built).
        fill_bg(0);
        mags[200] = MW'(500);
        run_frame(NS - 1, 0, 1'b0);

        // Frame B: large sub-MIN_BIN bin must be ignored.
        fill_bg(1);
        mags[1]  = MW'(9000);
        mags[40] = MW'(800);
        run_frame(NS - 1, 0, 1'b0);

        // Frame C: tie keeps the lower index; long consumer stall.
        fill_bg(1);
        mags[30] = MW'(7000);
        mags[60] = MW'(7000);
        run_frame(NS - 1, 50, 1'b0);

        // Frame E: wide random magnitudes.
        fill_bg(2);
        run_frame(NS - 1, 3, 1'b0);

        // Frame F: early mag_last sets the sticky error; mirrored-half bins are ignored.
        fill_bg(1);
        mags[450] = MW'(3000);
        mags[550] = MW'(99999);
        run_frame(600, 2, 1'b0);

        // Frame G: normal frame, error must stay set.
        fill_bg(0);
        mags[300] = MW'(2000);
        run_frame(NS - 1, 0, 1'b0);

        // Reset in the middle of a fill.
        send_frame(500, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        bus_if.audio_in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.audio_in_valid = 1'b0;
        #1;
        check_reset("rst_mid");
        reset       = 1'b0;
        exp_err     = 1'b0;
        prev_result = 0;

        // Frame H: boundary bins MIN_BIN and NS/2-1 tie; first mirrored bin larger but ignored.
        fill_bg(1);
        mags[MIN_BIN]    = MW'(4000);
        mags[NS / 2 - 1] = MW'(4000);
        mags[NS / 2]     = MW'(9999);
        run_frame(NS - 1, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
